// File: rtl/loop_sequencer.sv
`default_nettype none
// loop_sequencer rev 1.0: record/play looper driving a single-outstanding external RAM port.
// Define LOOP_OVERDUB_EN to enable the OVERDUB state (read, output, saturating write-back).
module loop_sequencer #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              rec_pulse,
    input  logic              stop_pulse,
    input  logic [DATA_W-1:0] sample_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic [DATA_W-1:0] sample_out,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] loop_len,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECORD  = 2'd1,
        PLAY    = 2'd2,
        OVERDUB = 2'd3
    } state_t;

    typedef struct packed {
        state_t            st;
        logic [ADDR_W-1:0] ptr;
        logic [ADDR_W-1:0] len;
    } ctx_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_MAX - ADDR_W'(1);

    state_t            fsm;
    logic [ADDR_W-1:0] ptr;
    logic              pend_rec;
    logic              pend_stop;
    logic              od_wr;

    ctx_t              nx;
    logic              n_req, n_we, n_overrun, n_prec, n_pstop, n_od_wr;
    logic [ADDR_W-1:0] n_addr;
    logic [DATA_W-1:0] n_wdata, n_out;
    logic [ADDR_W-1:0] play_next;

    assign state     = fsm;
    assign play_next = (ptr == loop_len - ADDR_W'(1)) ? '0 : ptr + ADDR_W'(1);

    function automatic ctx_t apply_cmd(input ctx_t c, input logic rec, input logic stop);
        ctx_t r = c;
        if (stop) begin
            r.st = IDLE;
        end else if (rec) begin
            case (c.st)
                IDLE: begin
                    r.st  = RECORD;
                    r.ptr = '0;
                end
                RECORD: begin
                    if (c.ptr == '0) begin
                        r.st = IDLE;
                    end else begin
                        r.st  = PLAY;
                        r.len = c.ptr;
                        r.ptr = '0;
                    end
                end
`ifdef LOOP_OVERDUB_EN
                PLAY:    r.st = OVERDUB;
                OVERDUB: r.st = PLAY;
`endif
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
    endfunction

    always_comb begin
        nx.st     = fsm;
        nx.ptr    = ptr;
        nx.len    = loop_len;
        n_req     = mem_req;
        n_we      = mem_we;
        n_addr    = mem_addr;
        n_wdata   = mem_wdata;
        n_out     = sample_out;
        n_overrun = overrun;
        n_prec    = pend_rec;
        n_pstop   = pend_stop;
        n_od_wr   = od_wr;

        // While busy, ticks are dropped and commands wait for completion; stop beats rec.
        if (mem_req || od_wr) begin
            if (sample_tick) n_overrun = 1'b1;
            if (stop_pulse) begin
                n_pstop = 1'b1;
                n_prec  = 1'b0;
            end else if (rec_pulse && !pend_stop) begin
                n_prec = 1'b1;
            end
        end

        if (od_wr) begin
            n_req   = 1'b1;
            n_addr  = ptr;
            n_od_wr = 1'b0;
        end else if (mem_req) begin
            if (mem_done) begin
                n_req = 1'b0;
                case (fsm)
                    RECORD: begin
                        if (ptr == LAST_WR) begin
                            nx.st  = PLAY;
                            nx.len = ADDR_MAX;
                            nx.ptr = '0;
                        end else begin
                            nx.ptr = ptr + ADDR_W'(1);
                        end
                    end
                    PLAY: begin
                        n_out  = mem_rdata;
                        nx.ptr = play_next;
                    end
                    OVERDUB: begin
                        if (!mem_we) begin
                            n_out   = mem_rdata;
                            n_wdata = sat_add(mem_rdata, sample_in);
                            n_we    = 1'b1;
                            n_od_wr = 1'b1;
                        end else begin
                            nx.ptr = play_next;
                        end
                    end
                    default: ;
                endcase
                if (!n_od_wr) begin
                    nx      = apply_cmd(nx, n_prec, n_pstop);
                    n_prec  = 1'b0;
                    n_pstop = 1'b0;
                end
            end
        end else begin
            nx = apply_cmd(nx, rec_pulse & ~stop_pulse, stop_pulse);
            if (sample_tick) begin
                case (nx.st)
                    RECORD: begin
                        n_req   = 1'b1;
                        n_we    = 1'b1;
                        n_addr  = nx.ptr;
                        n_wdata = sample_in;
                    end
                    PLAY, OVERDUB: begin
                        n_req  = 1'b1;
                        n_we   = 1'b0;
                        n_addr = nx.ptr;
                    end
                    default: ;
                endcase
            end
        end

        if (nx.st == IDLE) n_out = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            ptr        <= '0;
            loop_len   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            sample_out <= '0;
            overrun    <= 1'b0;
            pend_rec   <= 1'b0;
            pend_stop  <= 1'b0;
            od_wr      <= 1'b0;
        end else begin
            fsm        <= nx.st;
            ptr        <= nx.ptr;
            loop_len   <= nx.len;
            mem_req    <= n_req;
            mem_we     <= n_we;
            mem_addr   <= n_addr;
            mem_wdata  <= n_wdata;
            sample_out <= n_out;
            overrun    <= n_overrun;
            pend_rec   <= n_prec;
            pend_stop  <= n_pstop;
            od_wr      <= n_od_wr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loop_sequencer.sv
`default_nettype none
// tb_loop_sequencer: directed stimulus with a request/sample scoreboard and a RAM responder model.
module tb_loop_sequencer;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_tick = 1'b0;
    logic          rec_pulse = 1'b0;
    logic          stop_pulse = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic [DW-1:0] sample_out;
    logic [1:0]    state;
    logic [AW-1:0] loop_len;
    logic          overrun;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            delay = 0;
    logic          force_done = 1'b0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    loop_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .rec_pulse(rec_pulse), .stop_pulse(stop_pulse), .sample_in(sample_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .sample_out(sample_out),
        .state(state), .loop_len(loop_len), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        exp_q.push_back(t);
    endtask

    task automatic pulse(input logic t, input logic r, input logic s);
        @(negedge clk);
        sample_tick = t; rec_pulse = r; stop_pulse = s;
        @(negedge clk);
        sample_tick = 1'b0; rec_pulse = 1'b0; stop_pulse = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int quiet = 0;
        for (int i = 0; i < bound && quiet < 3; i++) begin
            @(posedge clk); #1;
            quiet = (mem_req || mem_done) ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: still busy after %0d cycles", bound);
        end
    endtask

    // RAM responder: completes each request after 'delay' cycles with a one-cycle mem_done.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_done) begin
                mem_done = 1'b0;
                cnt = 0;
            end else if (force_done) begin
                mem_done = 1'b1;
            end else if (mem_req) begin
                if (cnt >= delay) begin
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem[mem_addr];
                    mem_done = 1'b1;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every new request is matched against the queue; reads check sample_out after completion.
    initial begin
        logic prev_req = 1'b0;
        txn_t cur;
        cur.we = 1'b1; cur.addr = '0; cur.data = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: we=%0b addr=%0h, no request expected", mem_we, mem_addr);
                end else begin
                    cur = exp_q.pop_front();
                    check("req_we", 32'(mem_we), 32'(cur.we));
                    check("req_addr", 32'(mem_addr), 32'(cur.addr));
                    if (cur.we) check("req_wdata", 32'(mem_wdata), 32'(cur.data));
                end
            end
            if (prev_req && !mem_req && mem_done && !cur.we)
                check("sample_out", 32'(sample_out), 32'(cur.data));
            prev_req = mem_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_len", 32'(loop_len), 0);
        check("rst_out", 32'(sample_out), 0);
        check("rst_ovr", 32'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;

        // Record 1..4 then close the loop.
        pulse(0, 1, 0);
        check("rec_state", 32'(state), 1);
        for (int i = 1; i <= 4; i++) begin
            sample_in = DW'(i);
            push(1'b1, AW'(i - 1), DW'(i));
            pulse(1, 0, 0);
            if (i == 1) check("req_after_tick", 32'(mem_req), 1);
            wait_idle(50);
        end
        pulse(0, 1, 0);
        check("rec_len", 32'(loop_len), 4);
        check("rec_to_play", 32'(state), 2);

        // Playback wraps 0..3,0,1.
        for (int k = 0; k < 6; k++) begin
            push(1'b0, AW'(k % 4), DW'(k % 4 + 1));
            pulse(1, 0, 0);
            wait_idle(50);
        end

        // Slow memory: second tick dropped.
        delay = 3000;
        push(1'b0, AW'(2), DW'(3));
        pulse(1, 0, 0);
        repeat (5) @(negedge clk);
        pulse(1, 0, 0);
        check("overrun_set", 32'(overrun), 1);
        wait_idle(4000);
        delay = 0;
        check("overrun_sticky", 32'(overrun), 1);

        pulse(0, 0, 1);
        check("stop_idle", 32'(state), 0);
        check("stop_keep_len", 32'(loop_len), 4);
        check("idle_out", 32'(sample_out), 0);
        pulse(1, 0, 0);
        wait_idle(10);

        // Stop together with rec during an outstanding write.
        pulse(0, 1, 0);
        delay = 5;
        sample_in = 16'h0055;
        push(1'b1, AW'(0), 16'h0055);
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        check("cmd_latched_state", 32'(state), 1);
        check("cmd_latched_req", 32'(mem_req), 1);
        wait_idle(50);
        delay = 0;
        check("stopwin_state", 32'(state), 0);
        check("stopwin_len", 32'(loop_len), 4);

        // Fill to the top address; auto-enter PLAY.
        pulse(0, 1, 0);
        for (int i = 0; i < 15; i++) begin
            sample_in = DW'(16'h0100 + i);
            push(1'b1, AW'(i), DW'(16'h0100 + i));
            if (i == 14) check("pre_full_state", 32'(state), 1);
            pulse(1, 0, 0);
            wait_idle(50);
        end
        check("full_state", 32'(state), 2);
        check("full_len", 32'(loop_len), 15);
        push(1'b0, AW'(0), 16'h0100);
        pulse(1, 0, 0);
        wait_idle(50);

        // Empty recording returns to IDLE.
        pulse(0, 0, 1);
        pulse(0, 1, 0);
        pulse(0, 1, 0);
        check("empty_rec_idle", 32'(state), 0);
        check("empty_rec_len", 32'(loop_len), 15);

        // Command and tick in the same cycle: tick served in the new state.
        sample_in = 16'h00AA;
        push(1'b1, AW'(0), 16'h00AA);
        pulse(1, 1, 0);
        wait_idle(50);
        sample_in = 16'h00BB;
        push(1'b1, AW'(1), 16'h00BB);
        pulse(1, 0, 0);
        wait_idle(50);
        push(1'b0, AW'(0), 16'h00AA);
        pulse(1, 1, 0);
        wait_idle(50);
        check("rectick_state", 32'(state), 2);
        check("rectick_len", 32'(loop_len), 2);

        // Reset mid-read, then a stray completion.
        delay = 10;
        push(1'b0, AW'(1), 16'h00BB);
        pulse(1, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req), 0);
        check("rst_mid_state", 32'(state), 0);
        check("rst_mid_len", 32'(loop_len), 0);
        @(negedge clk);
        rst = 1'b0;
        delay = 0;
        @(posedge clk); #1 force_done = 1'b1;
        @(posedge clk); #1 force_done = 1'b0;
        wait_idle(10);
        check("late_done_state", 32'(state), 0);
        check("late_done_out", 32'(sample_out), 0);

        // Two-sample loop for the PLAY rec-command behaviour.
        pulse(0, 1, 0);
        sample_in = 16'h7000;
        push(1'b1, AW'(0), 16'h7000);
        pulse(1, 0, 0);
        wait_idle(50);
        sample_in = 16'h8000;
        push(1'b1, AW'(1), 16'h8000);
        pulse(1, 0, 0);
        wait_idle(50);
        pulse(0, 1, 0);
        pulse(0, 1, 0);
`ifdef LOOP_OVERDUB_EN
        check("overdub_state", 32'(state), 3);
        sample_in = 16'h2000;
        push(1'b0, AW'(0), 16'h7000);
        push(1'b1, AW'(0), 16'h7FFF);
        pulse(1, 0, 0);
        wait_idle(50);
        sample_in = 16'hF000;
        push(1'b0, AW'(1), 16'h8000);
        push(1'b1, AW'(1), 16'h8000);
        pulse(1, 0, 0);
        wait_idle(50);
        pulse(0, 1, 0);
        check("overdub_back", 32'(state), 2);
`else
        check("play_rec_ignored", 32'(state), 2);
`endif

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
